core_sequencer: RTL and testbench



---
 rtl/core_sequencer.sv | 154 +++++++++++++++
 tb/tb_core_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Run controller for the tape CPU. While the core is held stopped it owns the
// write ports of the tape and program memories. A session runs like this:
// optionally zero the whole tape, stream a program into program memory over a
// valid/ready port, run the core until its program counter leaves the program,
// then pulse done and return to idle.
//
// Ports
//   clock, reset            sole clock; asynchronous active-high reset
//   start                   begins a session (sampled only in IDLE)
//   prog_valid/ready/data/last
//                           program stream (3-bit opcodes, last marks the end)
//   core_pc                 the core's program counter, watched during RUN
//   core_run                high only in RUN; low holds the core stopped
//   tape_we/addr/wdata      tape clear port (data is always zero)
//   pmem_we/addr/wdata      program memory write port, one cycle after a beat
//   prog_len                number of opcodes loaded by the last load
//   busy, done, error       status: not idle, run-complete pulse, sticky overflow
//
// Every output is a register or a decode of registered state; prog_ready
// depends on the load-phase state only.
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter int TAPE_AW    = 16,
    parameter int PMEM_AW    = 16,
    parameter bit CLEAR_TAPE = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [2:0]         prog_data,
    input  logic               prog_last,
    input  logic [PMEM_AW-1:0] core_pc,
    output logic               core_run,
    output logic               tape_we,
    output logic [TAPE_AW-1:0] tape_addr,
    output logic [7:0]         tape_wdata,
    output logic               pmem_we,
    output logic [PMEM_AW-1:0] pmem_addr,
    output logic [2:0]         pmem_wdata,
    output logic [PMEM_AW:0]   prog_len,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [TAPE_AW-1:0] tape_cnt_q;
    logic [PMEM_AW-1:0] pmem_cnt_q;
    // Set by the final accepted beat: the load phase spends one more cycle
    // issuing that beat's write before leaving, and accepts nothing meanwhile.
    logic               drain_q;
    logic               pmem_we_q;
    logic [PMEM_AW-1:0] pmem_addr_q;
    logic [2:0]         pmem_wdata_q;
    logic [PMEM_AW:0]   prog_len_q;
    logic               error_q;

    // Length recorded by the final beat. One bit wider than the counter so a
    // beat at the last address yields 2^PMEM_AW, both for a legal last beat
    // and for an overflow.
    logic [PMEM_AW:0]   prog_len_d;
    assign prog_len_d = {1'b0, pmem_cnt_q} + (PMEM_AW + 1)'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tape_cnt_q   <= '0;
            pmem_cnt_q   <= '0;
            drain_q      <= 1'b0;
            pmem_we_q    <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            prog_len_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            // NOTE: every state register here uses non-blocking assignment so
            // all of them update together from the values before the edge.
            pmem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (CLEAR_TAPE) state_q <= S_CLEAR;
                        else            state_q <= S_LOAD;
                        tape_cnt_q <= '0;
                        pmem_cnt_q <= '0;
                        drain_q    <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    // The counter wraps back to 0 after the last tape address,
                    // which is exactly the value it needs on leaving CLEAR.
                    tape_cnt_q <= tape_cnt_q + TAPE_AW'(1);
                    if (tape_cnt_q == '1) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (drain_q) begin
                        drain_q <= 1'b0;
                        if (error_q) state_q <= S_IDLE;
                        else         state_q <= S_RUN;
                    end else if (prog_valid) begin
                        pmem_we_q    <= 1'b1;
                        pmem_addr_q  <= pmem_cnt_q;
                        pmem_wdata_q <= prog_data;
                        pmem_cnt_q   <= pmem_cnt_q + PMEM_AW'(1);
                        // A beat filling the last address without prog_last is
                        // an overflow: it is still written, but the core never runs.
                        if (prog_last || pmem_cnt_q == '1) begin
                            prog_len_q <= prog_len_d;
                            drain_q    <= 1'b1;
                            if (!prog_last) error_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if ({1'b0, core_pc} >= prog_len_q) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign prog_ready = (state_q == S_LOAD) && !drain_q;
    assign core_run   = (state_q == S_RUN);
    assign tape_we    = (state_q == S_CLEAR);
    assign tape_addr  = tape_cnt_q;
    assign tape_wdata = '0;
    assign pmem_we    = pmem_we_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    assign prog_len   = prog_len_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//
// Two sequencers with small memories: dut clears the tape before loading,
// dut_nc skips the clear. Program writes are collected by a monitor and
// compared with the reference rule "beat i is written to address i with its
// opcode"; prog_len is the beat count, or 2^PMEM_AW on overflow.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

    localparam int TAW = 4;
    localparam int PAW = 3;
    localparam int TAPE_CELLS = 1 << TAW;
    localparam int PMEM_CELLS = 1 << PAW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // dut (tape clear enabled)
    logic           start, prog_valid, prog_last;
    logic [2:0]     prog_data;
    logic [PAW-1:0] core_pc;
    logic           prog_ready, core_run, tape_we, pmem_we, busy, done, error;
    logic [TAW-1:0] tape_addr;
    logic [7:0]     tape_wdata;
    logic [PAW-1:0] pmem_addr;
    logic [2:0]     pmem_wdata;
    logic [PAW:0]   prog_len;

    // dut_nc (tape clear skipped)
    logic           b_start, b_valid, b_last;
    logic [2:0]     b_data;
    logic [PAW-1:0] b_pc;
    logic           b_ready, b_run, b_tape_we, b_pmem_we, b_busy, b_done, b_error;
    logic [TAW-1:0] b_tape_addr;
    logic [7:0]     b_tape_wdata;
    logic [PAW-1:0] b_pmem_addr;
    logic [2:0]     b_pmem_wdata;
    logic [PAW:0]   b_prog_len;

    core_sequencer #(.TAPE_AW(TAW), .PMEM_AW(PAW), .CLEAR_TAPE(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
        .prog_last(prog_last), .core_pc(core_pc), .core_run(core_run),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
        .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .prog_len(prog_len), .busy(busy), .done(done), .error(error)
    );

    core_sequencer #(.TAPE_AW(TAW), .PMEM_AW(PAW), .CLEAR_TAPE(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .start(b_start),
        .prog_valid(b_valid), .prog_ready(b_ready), .prog_data(b_data),
        .prog_last(b_last), .core_pc(b_pc), .core_run(b_run),
        .tape_we(b_tape_we), .tape_addr(b_tape_addr), .tape_wdata(b_tape_wdata),
        .pmem_we(b_pmem_we), .pmem_addr(b_pmem_addr), .pmem_wdata(b_pmem_wdata),
        .prog_len(b_prog_len), .busy(b_busy), .done(b_done), .error(b_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write monitor and safety counters for dut.
    logic [PAW-1:0] addr_q[$];
    logic [2:0]     data_q[$];
    int overlap_cnt   = 0;
    int run_write_cnt = 0;
    int run_cycles    = 0;

    always @(negedge clock) begin
        if (pmem_we) begin
            addr_q.push_back(pmem_addr);
            data_q.push_back(pmem_wdata);
        end
        if (pmem_we && tape_we) overlap_cnt++;
        if (core_run && (pmem_we || tape_we)) run_write_cnt++;
        if (core_run) run_cycles++;
    end

    logic [2:0] exp_ops [PMEM_CELLS];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_session();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'(1));
    endtask

    // Called in the first CLEAR cycle; returns in the first LOAD cycle.
    task automatic run_clear();
        for (int i = 0; i < TAPE_CELLS; i++) begin
            check("clear_we",   32'(tape_we),    32'(1));
            check("clear_addr", 32'(tape_addr),  32'(i));
            check("clear_data", 32'(tape_wdata), 32'(0));
            step();
        end
        check("clear_end_we",    32'(tape_we),    32'(0));
        check("clear_end_ready", 32'(prog_ready), 32'(1));
    endtask

    // Streams exp_ops[0..n-1] with random idle gaps (garbage data, stray start
    // pulses); returns in the cycle carrying the final beat's write.
    task automatic load_prog(input int n, input bit last_at_end, input int gap_max);
        addr_q.delete();
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gaps; g++) begin
                prog_valid = 1'b0;
                prog_data  = 3'($urandom);
                prog_last  = 1'($urandom);
                start      = 1'($urandom);
                step();
            end
            start      = 1'b0;
            prog_valid = 1'b1;
            prog_data  = exp_ops[i];
            prog_last  = last_at_end && (i == n - 1);
            check("load_ready", 32'(prog_ready), 32'(1));
            step();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        check("final_write_we",   32'(pmem_we),   32'(1));
        check("final_write_addr", 32'(pmem_addr), 32'(n - 1));
        check("final_write_run",  32'(core_run),  32'(0));
    endtask

    task automatic verify_writes(input int n);
        check("wr_count", 32'(addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            check("wr_addr", 32'(addr_q[i]), 32'(i));
            check("wr_data", 32'(data_q[i]), 32'(exp_ops[i]));
        end
    endtask

    // Called in the first RUN cycle; returns back in IDLE.
    task automatic run_prog(input int len, input int n_inside, input bit directed);
        for (int k = 0; k < n_inside; k++) begin
            check("run_active", 32'(core_run), 32'(1));
            check("run_nodone", 32'(done),     32'(0));
            core_pc = directed ? PAW'(k) : PAW'($urandom_range(len - 1, 0));
            start   = (k == 1);
            step();
        end
        start = 1'b0;
        check("run_before_end", 32'(core_run), 32'(1));
        core_pc = directed ? PAW'(len) : PAW'($urandom_range(PMEM_CELLS - 1, len));
        step();
        check("done_pulse", 32'(done),     32'(1));
        check("done_run",   32'(core_run), 32'(0));
        check("done_busy",  32'(busy),     32'(1));
        core_pc = '0;
        step();
        check("after_done",      32'(done), 32'(0));
        check("after_done_busy", 32'(busy), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(busy),       32'(0));
        check({tag, "_run"},     32'(core_run),   32'(0));
        check({tag, "_tape_we"}, 32'(tape_we),    32'(0));
        check({tag, "_pmem_we"}, 32'(pmem_we),    32'(0));
        check({tag, "_len"},     32'(prog_len),   32'(0));
        check({tag, "_done"},    32'(done),       32'(0));
        check({tag, "_error"},   32'(error),      32'(0));
        check({tag, "_ready"},   32'(prog_ready), 32'(0));
    endtask

    initial begin
        int len;
        int saved_runs;

        reset = 1'b1;
        start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0; core_pc = '0;
        b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_pc = '0;
        #1;
        check_all_zero("reset");
        step();
        step();
        #2 reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'(0));

        // Directed clear, load of 0,0,4,1,5,7 and run to pc 6.
        begin_session();
        run_clear();
        exp_ops[0] = 3'd0; exp_ops[1] = 3'd0; exp_ops[2] = 3'd4;
        exp_ops[3] = 3'd1; exp_ops[4] = 3'd5; exp_ops[5] = 3'd7;
        load_prog(6, 1'b1, 0);
        check("dir_final_data", 32'(pmem_wdata), 32'(7));
        step();
        check("dir_run_rise", 32'(core_run), 32'(1));
        check("dir_pmem_off", 32'(pmem_we),  32'(0));
        check("dir_len",      32'(prog_len), 32'(6));
        verify_writes(6);
        run_prog(6, 6, 1'b1);

        // Randomized sessions: random lengths, stalls and stray start pulses.
        for (int s = 0; s < 4; s++) begin
            len = int'($urandom_range(PMEM_CELLS - 1, 1));
            for (int i = 0; i < len; i++) exp_ops[i] = 3'($urandom);
            begin_session();
            run_clear();
            load_prog(len, 1'b1, 3);
            step();
            check("rnd_run_rise", 32'(core_run), 32'(1));
            check("rnd_len",      32'(prog_len), 32'(len));
            verify_writes(len);
            run_prog(len, int'($urandom_range(4, 1)), 1'b0);
        end

        // Overflow: a full memory of beats with no prog_last.
        saved_runs = run_cycles;
        for (int i = 0; i < PMEM_CELLS; i++) exp_ops[i] = 3'($urandom);
        begin_session();
        run_clear();
        load_prog(PMEM_CELLS, 1'b0, 2);
        step();
        check("ovf_busy",  32'(busy),       32'(0));
        check("ovf_error", 32'(error),      32'(1));
        check("ovf_len",   32'(prog_len),   32'(PMEM_CELLS));
        check("ovf_run",   32'(core_run),   32'(0));
        verify_writes(PMEM_CELLS);
        step();
        check("ovf_never_ran", 32'(run_cycles), 32'(saved_runs));
        check("ovf_sticky",    32'(error),      32'(1));

        // Next start clears error; then reset lands in the middle of CLEAR.
        begin_session();
        check("restart_error", 32'(error), 32'(0));
        for (int i = 0; i < 5; i++) step();
        check("midclear_addr", 32'(tape_addr), 32'(5));
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_clear");
        #3 reset = 1'b0;
        step();
        check("rst_clear_idle", 32'(busy), 32'(0));

        // prog_last on the last address is legal; reset lands in RUN.
        for (int i = 0; i < PMEM_CELLS; i++) exp_ops[i] = 3'($urandom);
        begin_session();
        run_clear();
        load_prog(PMEM_CELLS, 1'b1, 1);
        step();
        check("full_run",   32'(core_run), 32'(1));
        check("full_len",   32'(prog_len), 32'(PMEM_CELLS));
        check("full_error", 32'(error),    32'(0));
        verify_writes(PMEM_CELLS);
        for (int i = 0; i < 3; i++) begin
            core_pc = PAW'($urandom);
            step();
            check("full_running", 32'(core_run), 32'(1));
        end
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_run");
        #3 reset = 1'b0;
        core_pc = '0;
        step();
        check("rst_run_idle", 32'(busy), 32'(0));

        check("no_we_overlap",   32'(overlap_cnt),   32'(0));
        check("no_write_in_run", 32'(run_write_cnt), 32'(0));

        // No-clear variant goes straight to LOAD.
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("nc_busy",    32'(b_busy),    32'(1));
        check("nc_ready",   32'(b_ready),   32'(1));
        check("nc_tape_we", 32'(b_tape_we), 32'(0));
        b_valid = 1'b1; b_data = 3'd6; b_last = 1'b1;
        step();
        b_valid = 1'b0; b_last = 1'b0;
        check("nc_pmem_we",   32'(b_pmem_we),    32'(1));
        check("nc_pmem_addr", 32'(b_pmem_addr),  32'(0));
        check("nc_pmem_data", 32'(b_pmem_wdata), 32'(6));
        step();
        check("nc_run", 32'(b_run),      32'(1));
        check("nc_len", 32'(b_prog_len), 32'(1));
        b_pc = PAW'(1);
        step();
        check("nc_done", 32'(b_done), 32'(1));
        b_pc = '0;
        step();
        check("nc_idle", 32'(b_busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
